// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and constants.
package if_fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_FULL
  } fetch_state_t;

  // Encoding of addi x0, x0, 0, used as the bubble instruction.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte distance between consecutive sequential fetches.
  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between fetch (master) and memory (slave).
interface if_fetch_unit_if #(
  parameter int XLEN = 64
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction returned while decode is stalled.
module fetch_skid_buf #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  import if_fetch_unit_pkg::*;

  // Clear beats load, load beats unload; the entry keeps its contents once emptied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= in_pc;
      instr <= in_instr;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request, loads IF/ID,
// drops stale responses after a redirect and parks one response during a stall.
module if_fetch_unit #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              pc_src,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              flush_ifid,
  if_fetch_unit_if.master   imem,
  output logic              ifid_valid,
  output logic [XLEN-1:0]   ifid_pc,
  output logic [31:0]       ifid_instr
);

  import if_fetch_unit_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_q, inflight_d;

  logic            buf_load, buf_unload, buf_clear;
  logic            buf_valid;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_instr;

  logic            new_valid;
  logic [XLEN-1:0] new_pc;
  logic [31:0]     new_instr;

  logic            ifid_valid_q;
  logic [XLEN-1:0] ifid_pc_q;
  logic [31:0]     ifid_instr_q;

  logic            req_fire;

  assign req_fire            = (state_q == S_REQ) && imem.imem_req_ready;
  assign imem.imem_req_valid = (state_q == S_REQ);
  assign imem.imem_req_addr  = pc_q;

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .unload   (buf_unload),
    .clear    (buf_clear),
    .in_pc    (inflight_q),
    .in_instr (imem.imem_rsp_data),
    .valid    (buf_valid),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );

  // State, PC and in-flight address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  // Next-state logic; a redirect always wins the PC update, whatever the state does.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    buf_clear  = 1'b0;
    new_valid  = 1'b0;
    new_pc     = inflight_q;
    new_instr  = imem.imem_rsp_data;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (req_fire) begin
          inflight_d = pc_q;
          pc_d       = pc_q + XLEN'(PC_INCR);
          state_d    = pc_src ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (pc_src) begin
            state_d = S_REQ;
          end else if (stall_if) begin
            buf_load = 1'b1;
            state_d  = S_FULL;
          end else begin
            new_valid = 1'b1;
            state_d   = S_REQ;
          end
        end else if (pc_src) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem.imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      S_FULL: begin
        if (pc_src) begin
          buf_clear = 1'b1;
          state_d   = S_REQ;
        end else if (!stall_if) begin
          buf_unload = 1'b1;
          new_valid  = buf_valid;
          new_pc     = buf_pc;
          new_instr  = buf_instr;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pc_src) begin
      pc_d = {branch_target[XLEN-1:2], 2'b00};
    end
  end

  // IF/ID register: flush beats stall, stall beats a new instruction, else bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else if (flush_ifid) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
    end else if (stall_if) begin
      ifid_valid_q <= ifid_valid_q;
    end else if (new_valid) begin
      ifid_valid_q <= 1'b1;
      ifid_pc_q    <= new_pc;
      ifid_instr_q <= new_instr;
    end else begin
      ifid_valid_q <= 1'b0;
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_valid_q ? ifid_instr_q : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small memory model and an IF/ID scoreboard.
module tb_if_fetch_unit;

  import if_fetch_unit_pkg::*;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] NO_PC   = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall_if;
  logic        pc_src;
  logic [63:0] branch_target;
  logic        flush_ifid;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;

  logic        ifid_valid2;
  logic [63:0] ifid_pc2;
  logic [31:0] ifid_instr2;

  int          checks;
  int          errors;
  int          n_loads;

  int          rsp_delay;
  bit          pending;
  int          cnt;
  logic [63:0] pend_addr;
  bit          drop_rsp;
  logic [63:0] last_pc;
  exp_t        sb[$];

  if_fetch_unit_if #(.XLEN(64)) bus ();
  if_fetch_unit_if #(.XLEN(64)) bus2 ();

  if_fetch_unit #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_if      (stall_if),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .flush_ifid    (flush_ifid),
    .imem          (bus.master),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr)
  );

  if_fetch_unit #(.XLEN(64), .RESET_PC(WRAP_PC)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_if      (1'b0),
    .pc_src        (1'b0),
    .branch_target (64'h0),
    .flush_ifid    (1'b0),
    .imem          (bus2.master),
    .ifid_valid    (ifid_valid2),
    .ifid_pc       (ifid_pc2),
    .ifid_instr    (ifid_instr2)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [63:0] addr);
    mem_data = addr[31:0] ^ 32'h5A5A_0003;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (ifid_valid === 1'b1 && ifid_pc !== last_pc) begin
      last_pc = ifid_pc;
      n_loads++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("[TB] FAIL sb_unexpected: observed pc %h expected no load", ifid_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_pc", ifid_pc, e.pc);
        check("sb_instr", {32'h0, ifid_instr}, {32'h0, e.instr});
      end
    end
  endtask

  // Advance one clock, then play memory and scoreboard for the new cycle.
  task automatic apply_stimulus();
    bit          fire;
    logic [63:0] a;
    logic [31:0] d;
    exp_t        e;
    fire = (bus.imem_req_valid === 1'b1) && (bus.imem_req_ready === 1'b1);
    a    = bus.imem_req_addr;
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = 1'b0;
    if (fire) begin
      pending   = 1'b1;
      cnt       = rsp_delay;
      pend_addr = a;
    end
    if (pending) begin
      if (cnt == 0) begin
        d = mem_data(pend_addr);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = d;
        pending = 1'b0;
        if (drop_rsp) begin
          drop_rsp = 1'b0;
        end else begin
          e.pc    = pend_addr;
          e.instr = d;
          sb.push_back(e);
        end
      end else begin
        cnt--;
      end
    end
    check_output();
  endtask

  initial begin
    checks = 0; errors = 0; n_loads = 0;
    rsp_delay = 0; pending = 1'b0; cnt = 0; pend_addr = '0; drop_rsp = 1'b0;
    last_pc = NO_PC;
    rst_n = 1'b0; stall_if = 1'b0; pc_src = 1'b0; flush_ifid = 1'b0; branch_target = '0;
    bus.imem_req_ready  = 1'b1; bus.imem_rsp_valid  = 1'b0; bus.imem_rsp_data  = '0;
    bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = '0;

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    check("rst_ifid_valid", {63'h0, ifid_valid}, 64'h0);
    check("rst_ifid_pc", ifid_pc, 64'h0);
    check("rst_ifid_instr", {32'h0, ifid_instr}, {32'h0, NOP_INSTR});
    check("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
    check("rst_req_addr", bus.imem_req_addr, 64'h0);
    check("rst_wrap_addr", bus2.imem_req_addr, WRAP_PC);

    rst_n = 1'b1;
    apply_stimulus();
    check("first_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
    check("first_req_addr", bus.imem_req_addr, 64'h0);
    check("wrap_first_addr", bus2.imem_req_addr, WRAP_PC);

    $display("[TB] zero-wait stream");
    apply_stimulus();
    check("wrap_second_addr", bus2.imem_req_addr, 64'h0);
    for (int i = 0; i < 9; i++) apply_stimulus();
    check("stream_loads", 64'(n_loads), 64'd5);
    check("stream_last_pc", ifid_pc, 64'h10);
    check("stream_sb_empty", 64'(sb.size()), 64'h0);

    $display("[TB] redirect while waiting");
    rsp_delay = 2;
    apply_stimulus();
    pc_src = 1'b1; branch_target = 64'h103; drop_rsp = 1'b1;
    apply_stimulus();
    pc_src = 1'b0;
    check("redir_req_valid_drop", {63'h0, bus.imem_req_valid}, 64'h0);
    check("redir_pc_aligned", bus.imem_req_addr, 64'h100);
    apply_stimulus();
    check("redir_state_drop", 64'(dut.state_q), 64'(S_DROP));
    apply_stimulus();
    check("redir_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
    check("redir_req_addr", bus.imem_req_addr, 64'h100);
    check("redir_ifid_invalid", {63'h0, ifid_valid}, 64'h0);
    rsp_delay = 0;
    apply_stimulus();
    apply_stimulus();
    check("redir_ifid_valid", {63'h0, ifid_valid}, 64'h1);
    check("redir_ifid_pc", ifid_pc, 64'h100);

    $display("[TB] stall with response in flight");
    stall_if = 1'b1;
    apply_stimulus();
    check("stall_hold_valid", {63'h0, ifid_valid}, 64'h1);
    check("stall_hold_pc", ifid_pc, 64'h100);
    apply_stimulus();
    check("stall_state_full", 64'(dut.state_q), 64'(S_FULL));
    check("stall_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
    check("stall_hold_pc2", ifid_pc, 64'h100);
    apply_stimulus();
    check("stall_state_full2", 64'(dut.state_q), 64'(S_FULL));
    check("stall_no_req2", {63'h0, bus.imem_req_valid}, 64'h0);
    stall_if = 1'b0;
    apply_stimulus();
    check("unstall_ifid_pc", ifid_pc, 64'h104);
    check("unstall_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);

    $display("[TB] flush with stall");
    flush_ifid = 1'b1; stall_if = 1'b1;
    apply_stimulus();
    check("flush_valid", {63'h0, ifid_valid}, 64'h0);
    check("flush_instr", {32'h0, ifid_instr}, {32'h0, NOP_INSTR});
    flush_ifid = 1'b0;
    apply_stimulus();
    check("flush_state_full", 64'(dut.state_q), 64'(S_FULL));
    stall_if = 1'b0;
    apply_stimulus();
    check("flush_after_pc", ifid_pc, 64'h108);

    $display("[TB] reset during drop");
    rsp_delay = 3;
    apply_stimulus();
    pc_src = 1'b1; branch_target = 64'h200; drop_rsp = 1'b1;
    apply_stimulus();
    pc_src = 1'b0;
    check("rdrop_state", 64'(dut.state_q), 64'(S_DROP));
    rst_n = 1'b0; bus.imem_req_ready = 1'b0;
    #1;
    check("rdrop_state_idle", 64'(dut.state_q), 64'(S_IDLE));
    check("rdrop_ifid_valid", {63'h0, ifid_valid}, 64'h0);
    check("rdrop_req_addr", bus.imem_req_addr, 64'h0);
    last_pc = NO_PC;
    #1;
    rst_n = 1'b1;
    apply_stimulus();
    apply_stimulus();
    check("stale_rsp_driven", {63'h0, bus.imem_rsp_valid}, 64'h1);
    apply_stimulus();
    check("stale_ifid_valid", {63'h0, ifid_valid}, 64'h0);
    check("stale_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
    check("stale_req_addr", bus.imem_req_addr, 64'h0);
    bus.imem_req_ready = 1'b1; rsp_delay = 0;
    apply_stimulus();
    apply_stimulus();
    check("restart_ifid_valid", {63'h0, ifid_valid}, 64'h1);
    check("restart_ifid_pc", ifid_pc, 64'h0);
    check("final_sb_empty", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
